// File: rtl/serial_dma_reader.sv
// Memory-to-serial upload engine: reads a block of bytes and sends each one
// as 8N1 serial (LSB first) on tx_o. All outputs are registered.
module serial_dma_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIVISOR    = 416
) (
  input  logic                  busclk_i,
  input  logic                  n_reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_adr_i,
  input  logic [15:0]           length_i,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic                  mem_rd_o,
  input  logic [7:0]            mem_dat_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int TW = $clog2(DIVISOR);
  localparam logic [TW-1:0]         TMR_LOAD = TW'(DIVISOR - 1);
  localparam logic [TW-1:0]         TMR_ONE  = TW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
      tx_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (start_i) begin
            if (length_i == 16'd0) begin
              done_d = 1'b1;
            end else begin
              addr_d  = base_adr_i;
              cnt_d   = length_i;
              rd_d    = 1'b1;
              state_d = FETCH;
            end
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          state_d = LATCH;
        end
        LATCH: begin
          // tx_d mirrors the start bit of the freshly loaded frame.
          shift_d = {1'b1, mem_dat_i, 1'b0};
          addr_d  = addr_q + ADR_ONE;
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            cnt_d = 16'd0;
          end
          timer_d = TMR_LOAD;
          bit_d   = 4'd9;
          tx_d    = 1'b0;
          state_d = SEND;
        end
        SEND: begin
          if (timer_q != {TW{1'b0}}) begin
            timer_d = timer_q - TMR_ONE;
          end else if (bit_q != 4'd0) begin
            shift_d = {1'b1, shift_q[9:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q - 4'd1;
            timer_d = TMR_LOAD;
          end else begin
            tx_d = 1'b1;
            if (cnt_q != 16'd0) begin
              rd_d    = 1'b1;
              state_d = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge busclk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      cnt_q   <= 16'd0;
      shift_q <= 10'd0;
      timer_q <= {TW{1'b0}};
      bit_q   <= 4'd0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_adr_o = addr_q;
  assign mem_rd_o  = rd_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_serial_dma_reader.sv
// Directed bench for serial_dma_reader at DIVISOR=4 with a small read-only
// memory model that answers each read strobe.
module tb_serial_dma_reader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base = 16'h0000;
  logic [15:0] len = 16'h0000;
  logic [15:0] adr;
  logic        rd;
  logic [7:0]  dat = 8'h00;
  logic        tx, busy, done;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [15:0] rd_log[$];

  bit seq0[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  bit seq1[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  serial_dma_reader #(.ADDR_WIDTH(16), .DIVISOR(4)) dut (
    .busclk_i  (clk),
    .n_reset_i (n_rst),
    .start_i   (start),
    .abort_i   (abort),
    .base_adr_i(base),
    .length_i  (len),
    .mem_adr_o (adr),
    .mem_rd_o  (rd),
    .mem_dat_i (dat),
    .tx_o      (tx),
    .busy_o    (busy),
    .done_o    (done)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h1234: mem_byte = 8'hA5;
      16'h1235: mem_byte = 8'h3C;
      default:  mem_byte = a[7:0] ^ a[15:8];
    endcase
  endfunction

  always @(negedge clk) begin
    if (rd) begin
      rd_log.push_back(adr);
      dat = mem_byte(adr);
    end
    if (done) done_seen++;
  end

  task automatic test_reset();
    int k;
    checks++; if (tx !== 1'b1)     begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (rd !== 1'b0)     begin failures++; $display("FAIL reset_rd got=%b exp=0", rd); end
    checks++; if (adr !== 16'h0)   begin failures++; $display("FAIL reset_adr got=%h exp=0000", adr); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk); base = 16'h1234; len = 16'd1; start = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL reset_midchar_tx got=%b exp=0", tx); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL reset_async_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    checks++; if (rd !== 1'b0)   begin failures++; $display("FAIL reset_async_rd got=%b exp=0", rd); end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    rd_log.delete();
    base = 16'h1235; len = 16'd1; start = 1'b1;
    k = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (done) begin k = i; break; end
    end
    checks++; if (k !== 42) begin failures++; $display("FAIL reset_restart_done_cycle got=%0d exp=42", k); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 16'h1235)
      begin failures++; $display("FAIL reset_restart_reads got_n=%0d exp_n=1 exp_adr=1235", rd_log.size()); end
  endtask

  task automatic test_two_byte(input bit restart);
    int c, o;
    logic exp_tx, exp_rd, exp_busy, exp_done;
    logic [15:0] exp_adr;
    rd_log.delete();
    @(negedge clk); base = 16'h1234; len = 16'd2; start = 1'b1;
    for (int k = 0; k <= 85; k++) begin
      @(negedge clk);
      if (k < 84) begin c = k / 42; o = k % 42; end else begin c = 2; o = 0; end
      exp_tx = 1'b1;
      if (c < 2 && o >= 2) exp_tx = (c == 0) ? seq0[(o - 2) / 4] : seq1[(o - 2) / 4];
      exp_rd   = (k == 0 || k == 42);
      exp_adr  = (k == 0) ? 16'h1234 : 16'h1235;
      exp_busy = (k < 84);
      exp_done = (k == 84);
      checks++; if (tx !== exp_tx) begin failures++; $display("FAIL two_byte_tx r=%0d k=%0d got=%b exp=%b", restart, k, tx, exp_tx); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL two_byte_rd r=%0d k=%0d got=%b exp=%b", restart, k, rd, exp_rd); end
      if (exp_rd) begin
        checks++; if (adr !== exp_adr) begin failures++; $display("FAIL two_byte_adr r=%0d k=%0d got=%h exp=%h", restart, k, adr, exp_adr); end
      end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL two_byte_busy r=%0d k=%0d got=%b exp=%b", restart, k, busy, exp_busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL two_byte_done r=%0d k=%0d got=%b exp=%b", restart, k, done, exp_done); end
      if (k == 0) start = 1'b0;
      if (restart && k == 20) begin base = 16'h0100; len = 16'd5; start = 1'b1; end
      if (restart && k == 21) start = 1'b0;
    end
    checks++; if (rd_log.size() != 2) begin failures++; $display("FAIL two_byte_nreads r=%0d got=%0d exp=2", restart, rd_log.size()); end
  endtask

  task automatic test_wrap();
    int k;
    rd_log.delete();
    @(negedge clk); base = 16'hFFFF; len = 16'd2; start = 1'b1;
    k = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (done) begin k = i; break; end
    end
    checks++; if (k !== 84) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=84", k); end
    checks++; if (rd_log.size() != 2) begin failures++; $display("FAIL wrap_nreads got=%0d exp=2", rd_log.size()); end
    else begin
      checks++; if (rd_log[0] !== 16'hFFFF) begin failures++; $display("FAIL wrap_adr0 got=%h exp=ffff", rd_log[0]); end
      checks++; if (rd_log[1] !== 16'h0000) begin failures++; $display("FAIL wrap_adr1 got=%h exp=0000", rd_log[1]); end
    end
  endtask

  task automatic test_zero_length();
    rd_log.delete();
    @(negedge clk); base = 16'h4000; len = 16'd0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      checks++; if (done !== (k == 0)) begin failures++; $display("FAIL zero_done k=%0d got=%b exp=%b", k, done, (k == 0)); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy k=%0d got=%b exp=0", k, busy); end
      checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL zero_tx k=%0d got=%b exp=1", k, tx); end
    end
    checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_log.size()); end
  endtask

  task automatic test_abort();
    int done_before;
    rd_log.delete();
    done_before = done_seen;
    @(negedge clk); base = 16'h2000; len = 16'd3; start = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    // bit 3 of the frame for byte 0x20 is data bit 2 = 0
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL abort_pre_tx got=%b exp=0", tx); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL abort_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (rd !== 1'b0)   begin failures++; $display("FAIL abort_rd got=%b exp=0", rd); end
    repeat (150) @(negedge clk);
    checks++; if (rd_log.size() != 1) begin failures++; $display("FAIL abort_reads got=%0d exp=1", rd_log.size()); end
    checks++; if (done_seen != done_before) begin failures++; $display("FAIL abort_done got=%0d exp=%0d", done_seen, done_before); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
  endtask

  initial begin
    #1 n_rst = 1'b0;
    #12;
    test_reset();
    test_two_byte(1'b0);
    test_wrap();
    test_zero_length();
    test_two_byte(1'b1);
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
